coordinate_transmitter: RTL and testbench
=========================================

COORDINATE_TRANSMITTER -- requirements
Module: coordinate_transmitter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, clk cycles per UART bit (10 MHz / 115200 baud).
REQ-002 SHALL have parameter AUTO_SEND, default 1, meaning 1 = start a frame automatically when x or y differs from last sent value.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port x  input  8  current x-coordinate.
REQ-006 SHALL have port y  input  8  current y-coordinate.
REQ-007 SHALL have port send  input  1  one-cycle request to transmit a frame.
REQ-008 SHALL have port tx  output  1  UART transmit line, 8N1, LSB first, idle high.
REQ-009 SHALL have port busy  output  1  high from frame start through last stop bit.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a frame completes.

Function
REQ-011 Frame SHALL be 6 bytes in order: 'X' (0x58), digit(x), 'Y' (0x59), digit(y), CR (0x0D), LF (0x0A).
REQ-012 digit(v) SHALL be 0x30 + v when v <= 9, else '?' (0x3F).
REQ-013 x and y SHALL be snapshotted into registers on the cycle a frame starts; input changes during a frame SHALL NOT alter bytes of that frame.
REQ-014 Each byte SHALL be: start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly CLKS_PER_BIT cycles; no idle gap between bytes of one frame.
REQ-015 Frame length SHALL be exactly 60 * CLKS_PER_BIT cycles.
REQ-016 FSM states: IDLE, START, DATA, STOP; byte index counter 0..5, bit index 0..7, baud counter 0..CLKS_PER_BIT-1.
REQ-017 IDLE -> START on trigger (send, pending, or auto-change); tx SHALL fall on the first rising edge after the triggering cycle (latency 1 cycle).
REQ-018 START -> DATA after CLKS_PER_BIT cycles; DATA -> STOP after 8 bits; STOP -> START (next byte) if byte index < 5, else STOP -> IDLE.
REQ-019 busy SHALL assert the same edge tx first falls and deassert with the STOP -> IDLE transition; done SHALL pulse for exactly that one cycle.
REQ-020 Auto-change (AUTO_SEND=1): trigger when {x,y} != last-sent snapshot while in IDLE; after reset the last-sent snapshot SHALL be 0x00/0x00.
REQ-021 send while busy SHALL set a single pending flag; multiple requests during one frame collapse into one; pending SHALL clear when the next frame starts.
REQ-022 After a frame, a pending or auto trigger SHALL start the next frame with tx high for exactly 1 idle cycle minimum (IDLE state occupancy).
REQ-023 send and auto-change in the same IDLE cycle SHALL start exactly one frame.
REQ-024 AUTO_SEND=0 SHALL ignore coordinate changes; only send triggers frames.

Reset
REQ-025 While reset is low: tx=1, busy=0, done=0, state IDLE, all counters 0, pending 0, snapshot 0x00/0x00.
REQ-026 Reset asserted mid-frame SHALL force tx high immediately (asynchronously), abandoning the frame; no done pulse.
REQ-027 First trigger evaluation SHALL occur on the first rising edge after reset release.

Verification
REQ-028 AUTO_SEND=0, CLKS_PER_BIT=4, x=3, y=4, send pulse -> bytes 0x58,0x33,0x59,0x34,0x0D,0x0A on tx, 240 cycles busy, one done pulse.
REQ-029 AUTO_SEND=1, after reset hold x=2,y=3 -> one frame "X2Y3\r\n" then tx idle high, no further frames while inputs stable.
REQ-030 x=12 with send -> second byte 0x3F.
REQ-031 Three send pulses during an active frame -> exactly one additional frame, started after 1 idle cycle.
REQ-032 Change x 1->4 at bit 20 of a frame -> current frame carries digit '1', following frame carries '4'.
REQ-033 Reset low at cycle 100 of a frame -> tx=1 and busy=0 within the same cycle, no done; after release with send=0 and AUTO_SEND=0, tx stays 1.

Source files
------------

// File: rtl/coordinate_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : coordinate_transmitter
// Description : Sends the current (x, y) coordinate pair as a six-byte ASCII
//               frame over an 8N1 UART line: 'X', digit(x), 'Y', digit(y),
//               CR, LF.  A frame is started by an explicit send request, by a
//               request parked while a frame was in flight, or (optionally)
//               automatically whenever the coordinates differ from those
//               carried by the last frame.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CLKS_PER_BIT : clk cycles per UART bit (87 -> 115200 baud at 10 MHz)
//   AUTO_SEND    : 1 = start a frame when {x,y} differs from last sent pair
// Ports
//   clk   in   1  system clock, all state on rising edge
//   reset in   1  asynchronous active-low reset
//   x     in   8  current x coordinate
//   y     in   8  current y coordinate
//   send  in   1  one-cycle frame request
//   tx    out  1  UART transmit line, idle high, LSB first
//   busy  out  1  high from the first start bit through the last stop bit
//   done  out  1  one-cycle pulse as the frame completes
// ============================================================================
module coordinate_transmitter #(
    parameter int CLKS_PER_BIT = 87,
    parameter int AUTO_SEND    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       send,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);

    localparam logic [2:0] LAST_BYTE = 3'd5;
    localparam logic [2:0] LAST_BIT  = 3'd7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [7:0] CH_X  = 8'h58;
    localparam logic [7:0] CH_Y  = 8'h59;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_Q  = 8'h3F;
    localparam logic [7:0] CH_0  = 8'h30;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] baud_q,     baud_d;
    logic [2:0]       bit_idx_q,  bit_idx_d;
    logic [2:0]       byte_idx_q, byte_idx_d;
    logic [7:0]       x_snap_q,   x_snap_d;
    logic [7:0]       y_snap_q,   y_snap_d;
    logic             pending_q,  pending_d;
    logic             tx_q,       tx_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic       w_baud_last;
    logic       w_coord_changed;
    logic       w_auto_trig;
    logic       w_start;
    logic [2:0] w_next_bit;
    logic [7:0] w_cur_byte;

    // Single decimal digit in ASCII; anything outside 0..9 is shown as '?'.
    function automatic logic [7:0] ascii_digit(input logic [7:0] v);
        if (v <= 8'd9) begin
            ascii_digit = CH_0 + v;
        end else begin
            ascii_digit = CH_Q;
        end
    endfunction

    assign w_baud_last     = (baud_q == BAUD_LAST);
    assign w_next_bit      = bit_idx_q + 3'd1;

    // The snapshot doubles as the "last sent" pair, so an auto frame fires
    // only when the live inputs have moved away from what was transmitted.
    assign w_coord_changed = ({x, y} != {x_snap_q, y_snap_q});
    assign w_auto_trig     = (AUTO_SEND != 0) && w_coord_changed;

    // Any combination of triggers in the same idle cycle starts one frame.
    assign w_start         = (state_q == ST_IDLE) && (send || pending_q || w_auto_trig);

    // Byte currently on the line, built from the frozen snapshot.
    always_comb begin
        w_cur_byte = CH_LF;
        case (byte_idx_q)
            3'd0:    w_cur_byte = CH_X;
            3'd1:    w_cur_byte = ascii_digit(x_snap_q);
            3'd2:    w_cur_byte = CH_Y;
            3'd3:    w_cur_byte = ascii_digit(y_snap_q);
            3'd4:    w_cur_byte = CH_CR;
            default: w_cur_byte = CH_LF;
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // tx is registered and is loaded with the value of the bit being entered,
    // so every transition below also decides what the line shows next.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        x_snap_d   = x_snap_q;
        y_snap_d   = y_snap_q;
        pending_d  = pending_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        // Requests arriving mid-frame collapse into a single parked request.
        if ((state_q != ST_IDLE) && send) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (w_start) begin
                    state_d    = ST_START;
                    baud_d     = '0;
                    bit_idx_d  = '0;
                    byte_idx_d = '0;
                    x_snap_d   = x;
                    y_snap_d   = y;
                    pending_d  = 1'b0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            ST_START: begin
                if (w_baud_last) begin
                    state_d   = ST_DATA;
                    baud_d    = '0;
                    bit_idx_d = '0;
                    tx_d      = w_cur_byte[0];
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end

            ST_DATA: begin
                if (w_baud_last) begin
                    baud_d = '0;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = w_next_bit;
                        tx_d      = w_cur_byte[w_next_bit];
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end

            ST_STOP: begin
                if (w_baud_last) begin
                    baud_d = '0;
                    if (byte_idx_q == LAST_BYTE) begin
                        // Returning to idle guarantees at least one high cycle
                        // before any back-to-back frame.
                        state_d    = ST_IDLE;
                        byte_idx_d = '0;
                        bit_idx_d  = '0;
                        tx_d       = 1'b1;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        state_d    = ST_START;
                        byte_idx_d = byte_idx_q + 3'd1;
                        bit_idx_d  = '0;
                        tx_d       = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                baud_d     = '0;
                bit_idx_d  = '0;
                byte_idx_d = '0;
                tx_d       = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // The asynchronous reset drives tx high at once, abandoning any frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            x_snap_q   <= '0;
            y_snap_q   <= '0;
            pending_q  <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            x_snap_q   <= x_snap_d;
            y_snap_q   <= y_snap_d;
            pending_q  <= pending_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_coordinate_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_coordinate_transmitter
// Description : Self-checking bench for coordinate_transmitter.  Two DUTs
//               (AUTO_SEND=0 and AUTO_SEND=1, CLKS_PER_BIT=4) share a clock.
//               Expected bytes are queued when stimulus is driven; a UART
//               monitor decodes tx and pops the queue per received byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coordinate_transmitter;

    localparam int CPB         = 4;
    localparam int FRAME_CYC   = 60 * CPB;
    localparam int WAIT_BUDGET = FRAME_CYC + 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_n;
    logic [7:0] x0, y0, x1, y1;
    logic       send0, send1;
    logic       tx0, busy0, done0;
    logic       tx1, busy1, done1;
    logic [1:0] tx_v, busy_v, done_v;

    assign tx_v   = {tx1, tx0};
    assign busy_v = {busy1, busy0};
    assign done_v = {done1, done0};

    coordinate_transmitter #(.CLKS_PER_BIT(CPB), .AUTO_SEND(0)) dut0 (
        .clk(clk), .reset(rst_n[0]), .x(x0), .y(y0), .send(send0),
        .tx(tx0), .busy(busy0), .done(done0)
    );

    coordinate_transmitter #(.CLKS_PER_BIT(CPB), .AUTO_SEND(1)) dut1 (
        .clk(clk), .reset(rst_n[1]), .x(x1), .y(y1), .send(send1),
        .tx(tx1), .busy(busy1), .done(done1)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] digit(input int v);
        if (v >= 0 && v <= 9) return 8'h30 + 8'(v);
        return 8'h3F;
    endfunction

    task automatic push_frame(input int d, input int xv, input int yv);
        logic [7:0] b [6];
        b[0] = 8'h58; b[1] = digit(xv); b[2] = 8'h59;
        b[3] = digit(yv); b[4] = 8'h0D; b[5] = 8'h0A;
        for (int i = 0; i < 6; i++) begin
            if (d == 0) exp_q0.push_back(b[i]);
            else        exp_q1.push_back(b[i]);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor: UART decode + busy/done framing, sampled on falling edges
    // ------------------------------------------------------------------------
    int         rx_cnt   [2];
    logic       rx_act   [2];
    logic [7:0] rx_byte  [2];
    int         busy_run [2];
    logic       busy_prev[2];
    int         done_cnt [2];

    initial begin
        int         slot;
        logic [7:0] exp_b;
        int         qsz;
        for (int d = 0; d < 2; d++) begin
            rx_cnt[d] = 0; rx_act[d] = 1'b0; rx_byte[d] = 8'h00;
            busy_run[d] = 0; busy_prev[d] = 1'b0; done_cnt[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst_n[d] !== 1'b1) begin
                    rx_act[d] = 1'b0; rx_cnt[d] = 0;
                    busy_run[d] = 0; busy_prev[d] = 1'b0;
                end else begin
                    if (!rx_act[d]) begin
                        if (tx_v[d] === 1'b0) begin
                            rx_act[d] = 1'b1;
                            rx_cnt[d] = 0;
                        end
                    end else begin
                        rx_cnt[d]++;
                    end
                    if (rx_act[d] && (rx_cnt[d] % CPB) == CPB / 2) begin
                        slot = rx_cnt[d] / CPB;
                        if (slot == 0) begin
                            check($sformatf("start_bit_d%0d", d), tx_v[d], 0);
                        end else if (slot <= 8) begin
                            rx_byte[d][slot-1] = tx_v[d];
                        end else begin
                            check($sformatf("stop_bit_d%0d", d), tx_v[d], 1);
                            qsz = (d == 0) ? exp_q0.size() : exp_q1.size();
                            check($sformatf("byte_expected_d%0d", d), qsz != 0, 1);
                            if (qsz != 0) begin
                                exp_b = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                                check($sformatf("rx_byte_d%0d", d), rx_byte[d], exp_b);
                            end
                            rx_act[d] = 1'b0;
                        end
                    end
                    if (busy_v[d]) busy_run[d]++;
                    if (done_v[d] === 1'b1) begin
                        done_cnt[d]++;
                        check($sformatf("done_on_busy_fall_d%0d", d), busy_prev[d] && !busy_v[d], 1);
                    end
                    if (busy_prev[d] && !busy_v[d]) begin
                        check($sformatf("busy_len_d%0d", d), busy_run[d], FRAME_CYC);
                        check($sformatf("done_at_busy_fall_d%0d", d), done_v[d], 1);
                        busy_run[d] = 0;
                    end
                    busy_prev[d] = busy_v[d];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int d, input string tag);
        int n;
        n = 0;
        while (done_v[d] !== 1'b1 && n < WAIT_BUDGET) begin
            step();
            n++;
        end
        check({tag, "_done_seen"}, done_v[d], 1);
    endtask

    int low;
    int base;

    initial begin
        rst_n = 2'b00;
        x0 = 8'd0; y0 = 8'd0; x1 = 8'd0; y1 = 8'd0;
        send0 = 1'b0; send1 = 1'b0;
        repeat (3) step();
        check("rst_tx0", tx0, 1);   check("rst_busy0", busy0, 0); check("rst_done0", done0, 0);
        check("rst_tx1", tx1, 1);   check("rst_busy1", busy1, 0); check("rst_done1", done1, 0);

        // Manual-only DUT ignores coordinate changes; explicit send of x=3,y=4
        x0 = 8'd3; y0 = 8'd4;
        rst_n[0] = 1'b1;
        low = 0;
        repeat (20) begin step(); if (tx0 !== 1'b1 || busy0 !== 1'b0) low++; end
        check("a_no_auto_frame", low, 0);
        push_frame(0, 3, 4);
        send0 = 1'b1; step(); send0 = 1'b0;
        check("a_tx_fall", tx0, 0);
        check("a_busy_rise", busy0, 1);
        base = done_cnt[0];
        wait_done(0, "a");
        step(); step();
        check("a_done_count", done_cnt[0] - base, 1);
        check("a_queue_empty", exp_q0.size(), 0);

        // x=12 -> '?', plus three requests mid-frame collapsing to one frame
        x0 = 8'd12; y0 = 8'd4;
        push_frame(0, 12, 4);
        send0 = 1'b1; step(); send0 = 1'b0;
        check("b_tx_fall", tx0, 0);
        repeat (50) step();
        x0 = 8'd7;
        repeat (3) begin send0 = 1'b1; step(); send0 = 1'b0; repeat (10) step(); end
        push_frame(0, 7, 4);
        base = done_cnt[0];
        wait_done(0, "b1");
        check("b_gap_tx_high", tx0, 1);
        check("b_gap_busy_low", busy0, 0);
        step();
        check("b_second_tx_fall", tx0, 0);
        check("b_second_busy", busy0, 1);
        wait_done(0, "b2");
        low = 0;
        repeat (300) begin step(); if (tx0 !== 1'b1) low++; end
        check("b_frame_count", done_cnt[0] - base, 2);
        check("b_idle_after", low, 0);
        check("b_queue_empty", exp_q0.size(), 0);

        // Reset deep into the third byte, while a 0 data bit is on the line
        x0 = 8'd5; y0 = 8'd4;
        push_frame(0, 5, 4);
        send0 = 1'b1; step(); send0 = 1'b0;
        check("c_tx_fall", tx0, 0);
        repeat (104) step();
        check("c_pre_reset_tx", tx0, 0);
        base = done_cnt[0];
        #2 rst_n[0] = 1'b0;
        #1;
        check("c_async_tx", tx0, 1);
        check("c_async_busy", busy0, 0);
        exp_q0.delete();
        repeat (5) step();
        check("c_rst_tx", tx0, 1);
        check("c_rst_done", done0, 0);
        rst_n[0] = 1'b1;
        low = 0;
        repeat (100) begin step(); if (tx0 !== 1'b1 || busy0 !== 1'b0) low++; end
        check("c_quiet_after_release", low, 0);
        check("c_no_done", done_cnt[0] - base, 0);

        // Auto-send DUT: coordinates held at 2,3 through reset release
        x1 = 8'd2; y1 = 8'd3;
        push_frame(1, 2, 3);
        rst_n[1] = 1'b1; step();
        check("d_auto_tx_fall", tx1, 0);
        check("d_auto_busy", busy1, 1);
        base = done_cnt[1];
        wait_done(1, "d");
        low = 0;
        repeat (300) begin step(); if (tx1 !== 1'b1) low++; end
        check("d_one_frame", done_cnt[1] - base, 1);
        check("d_idle_stable", low, 0);
        check("d_queue_empty", exp_q1.size(), 0);

        // x 1 -> 4 at bit 20 of the frame
        push_frame(1, 1, 3);
        x1 = 8'd1; step();
        check("e_tx_fall", tx1, 0);
        repeat (80) step();
        x1 = 8'd4;
        push_frame(1, 4, 3);
        base = done_cnt[1];
        wait_done(1, "e1");
        check("e_gap_tx_high", tx1, 1);
        step();
        check("e_second_tx_fall", tx1, 0);
        check("e_second_busy", busy1, 1);
        wait_done(1, "e2");
        step(); step();
        check("e_frame_count", done_cnt[1] - base, 2);
        check("e_queue_empty", exp_q1.size(), 0);

        // send and auto-change in the same idle cycle -> one frame
        push_frame(1, 6, 3);
        base = done_cnt[1];
        x1 = 8'd6; send1 = 1'b1; step(); send1 = 1'b0;
        check("f_tx_fall", tx1, 0);
        wait_done(1, "f");
        low = 0;
        repeat (300) begin step(); if (tx1 !== 1'b1) low++; end
        check("f_one_frame", done_cnt[1] - base, 1);
        check("f_idle_after", low, 0);
        check("f_queue_empty", exp_q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
